// File: rtl/ex_forward_controller.sv
// Execute-stage forwarding and load-use hazard controller: tracks the EX and MEM
// pipeline slots and registers the operand-mux selects for the instruction entering EX.
module ex_forward_controller #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_src_used,
  input  logic                  id_dst_used,
  input  logic                  id_imm_or_reg,
  input  logic                  id_wb_en,
  input  logic                  id_mem_read,
  output logic [1:0]            selectSrc,
  output logic [1:0]            selectDst,
  output logic                  stall,
  output logic                  ex_valid
);

  localparam logic [1:0] SEL_REGFILE = 2'b00;
  localparam logic [1:0] SEL_EX_MEM  = 2'b01;
  localparam logic [1:0] SEL_MEM_WB  = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  wb_en;
    logic                  mem_read;
  } ex_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  wb_en;
  } mem_slot_t;

  ex_slot_t  ex_q;
  mem_slot_t mem_q;

  logic       src_need, dst_need;
  logic       ex_alu_result, ex_load_result, mem_result;
  logic       src_ex_hit, dst_ex_hit, src_mem_hit, dst_mem_hit;
  logic       load_use;
  logic [1:0] next_sel_src, next_sel_dst;

  // An immediate operand 2 never reads a register, so it can neither forward nor stall.
  assign src_need = id_valid & id_src_used;
  assign dst_need = id_valid & id_dst_used & id_imm_or_reg;

  assign ex_alu_result  = ex_q.valid & ex_q.wb_en & ~ex_q.mem_read;
  assign ex_load_result = ex_q.valid & ex_q.wb_en &  ex_q.mem_read;
  assign mem_result     = mem_q.valid & mem_q.wb_en;

  assign src_ex_hit  = src_need & (id_src == ex_q.dst);
  assign dst_ex_hit  = dst_need & (id_dst == ex_q.dst);
  assign src_mem_hit = src_need & (id_src == mem_q.dst);
  assign dst_mem_hit = dst_need & (id_dst == mem_q.dst);

  // A load in EX has no value yet; the consumer waits one cycle and then picks it up from MEM.
  assign load_use = ex_load_result & (src_ex_hit | dst_ex_hit);
  assign stall    = load_use & ~flush;

  // The EX match is checked first so the newest producer wins.
  assign next_sel_src = (src_ex_hit  & ex_alu_result) ? SEL_EX_MEM :
                        (src_mem_hit & mem_result)    ? SEL_MEM_WB : SEL_REGFILE;
  assign next_sel_dst = (dst_ex_hit  & ex_alu_result) ? SEL_EX_MEM :
                        (dst_mem_hit & mem_result)    ? SEL_MEM_WB : SEL_REGFILE;

  assign ex_valid = ex_q.valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q      <= '0;
      mem_q     <= '0;
      selectSrc <= SEL_REGFILE;
      selectDst <= SEL_REGFILE;
    end else if (advance) begin
      // NOTE: non-blocking assignments let mem_q take the pre-edge ex_q and the selects see
      // the pre-edge slots, exactly like the pipeline registers they model.
      mem_q <= '{valid: ex_q.valid, dst: ex_q.dst, wb_en: ex_q.wb_en};
      if (flush || stall) begin
        ex_q      <= '0;
        selectSrc <= SEL_REGFILE;
        selectDst <= SEL_REGFILE;
      end else begin
        ex_q      <= '{valid: id_valid, dst: id_dst, wb_en: id_wb_en, mem_read: id_mem_read};
        selectSrc <= next_sel_src;
        selectDst <= next_sel_dst;
      end
    end
  end

endmodule

// File: tb/tb_ex_forward_controller.sv
// Scoreboard bench for ex_forward_controller: the driver queues hand-computed expectations
// per cycle, and a monitor pops and compares them against the DUT each cycle.
module tb_ex_forward_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       advance = 1'b0;
  logic       flush = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_src = '0;
  logic [2:0] id_dst = '0;
  logic       id_src_used = 1'b0;
  logic       id_dst_used = 1'b0;
  logic       id_imm_or_reg = 1'b0;
  logic       id_wb_en = 1'b0;
  logic       id_mem_read = 1'b0;
  logic [1:0] selectSrc, selectDst;
  logic       stall, ex_valid;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string      name;
    logic       st;
    logic       ev;
    logic [1:0] s;
    logic [1:0] d;
  } exp_t;

  exp_t sb[$];

  ex_forward_controller #(.REG_ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .advance(advance), .flush(flush),
    .id_valid(id_valid), .id_src(id_src), .id_dst(id_dst),
    .id_src_used(id_src_used), .id_dst_used(id_dst_used),
    .id_imm_or_reg(id_imm_or_reg), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .selectSrc(selectSrc), .selectDst(selectDst), .stall(stall), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One decode-stage cycle: drive inputs after the falling edge and queue the expected
  // stall (before the edge) and EX-stage outputs (after the edge).
  task automatic step(input string name, input logic v, input logic [2:0] src, input logic [2:0] dst,
                      input logic su, input logic du, input logic ir, input logic wb, input logic mr,
                      input logic fl, input logic adv, input logic e_st, input logic e_ev,
                      input logic [1:0] e_s, input logic [1:0] e_d);
    exp_t e;
    @(negedge clk);
    id_valid = v; id_src = src; id_dst = dst; id_src_used = su; id_dst_used = du;
    id_imm_or_reg = ir; id_wb_en = wb; id_mem_read = mr; flush = fl; advance = adv;
    e.name = name; e.st = e_st; e.ev = e_ev; e.s = e_s; e.d = e_d;
    sb.push_back(e);
  endtask

  initial begin : monitor
    logic st_sample;
    exp_t e;
    forever begin
      @(negedge clk);
      #3 st_sample = stall;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".stall"},     {7'd0, st_sample}, {7'd0, e.st});
        check({e.name, ".ex_valid"},  {7'd0, ex_valid},  {7'd0, e.ev});
        check({e.name, ".selectSrc"}, {6'd0, selectSrc}, {6'd0, e.s});
        check({e.name, ".selectDst"}, {6'd0, selectDst}, {6'd0, e.d});
      end
    end
  end

  initial begin : watchdog
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : driver
    #2;
    check("reset.stall",     {7'd0, stall},     8'd0);
    check("reset.ex_valid",  {7'd0, ex_valid},  8'd0);
    check("reset.selectSrc", {6'd0, selectSrc}, 8'd0);
    check("reset.selectDst", {6'd0, selectDst}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //    name        v src   dst   su du ir wb mr fl adv  st ev src   dst
    step("idle",      0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b00);
    // EX -> EX forwarding of the immediately preceding ALU result.
    step("add_r1",    1, 3'd0, 3'd1, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("use_r1",    1, 3'd1, 3'd2, 1, 1, 1, 1, 0, 0, 1,  0, 1, 2'b01, 2'b00);
    // MEM -> EX forwarding on operand 2, then the same with an immediate operand 2.
    step("prod_r3",   1, 3'd0, 3'd3, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("nowb_r6",   1, 3'd0, 3'd6, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("use_r3_reg",1, 3'd0, 3'd3, 1, 1, 1, 0, 0, 0, 1,  0, 1, 2'b00, 2'b10);
    step("prod_r3b",  1, 3'd0, 3'd3, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("nowb_r6b",  1, 3'd0, 3'd6, 0, 0, 0, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("use_r3_imm",1, 3'd0, 3'd3, 0, 1, 0, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    // Two producers of R4: EX wins over MEM on both operands.
    step("prod_r4a",  1, 3'd0, 3'd4, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("prod_r4b",  1, 3'd0, 3'd4, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("use_r4",    1, 3'd4, 3'd4, 1, 1, 1, 0, 0, 0, 1,  0, 1, 2'b01, 2'b01);
    // Operands forwarded from different stages in the same instruction.
    step("prod_r5",   1, 3'd0, 3'd5, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("prod_r6",   1, 3'd0, 3'd6, 0, 0, 0, 1, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("use_r6_r5", 1, 3'd6, 3'd5, 1, 1, 1, 0, 0, 0, 1,  0, 1, 2'b01, 2'b10);
    // Load-use: one stall with a bubble, then forwarding from MEM.
    step("load_r5",   1, 3'd0, 3'd5, 1, 0, 0, 1, 1, 0, 1,  0, 1, 2'b00, 2'b00);
    step("lu_stall",  1, 3'd5, 3'd2, 1, 0, 1, 1, 0, 0, 1,  1, 0, 2'b00, 2'b00);
    step("lu_resume", 1, 3'd5, 3'd2, 1, 0, 1, 1, 0, 0, 1,  0, 1, 2'b10, 2'b00);
    // Load-use coinciding with flush: no stall, bubble inserted.
    step("load_r5b",  1, 3'd0, 3'd5, 0, 0, 0, 1, 1, 0, 1,  0, 1, 2'b00, 2'b00);
    step("lu_flush",  1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 1, 1,  0, 0, 2'b00, 2'b00);
    step("after_fl",  1, 3'd5, 3'd1, 1, 0, 0, 1, 0, 0, 1,  0, 1, 2'b10, 2'b00);
    // Frozen pipeline: a consumer of R1 waits, nothing moves for three cycles.
    step("hold_1",    1, 3'd1, 3'd7, 1, 0, 0, 0, 0, 0, 0,  0, 1, 2'b10, 2'b00);
    step("hold_2",    1, 3'd1, 3'd7, 1, 0, 0, 0, 0, 0, 0,  0, 1, 2'b10, 2'b00);
    step("hold_3",    1, 3'd1, 3'd7, 1, 0, 0, 0, 0, 0, 0,  0, 1, 2'b10, 2'b00);
    step("unfreeze",  1, 3'd1, 3'd7, 1, 0, 0, 0, 0, 0, 1,  0, 1, 2'b01, 2'b00);
    step("load_r5c",  1, 3'd0, 3'd5, 0, 0, 0, 1, 1, 0, 1,  0, 1, 2'b00, 2'b00);

    // Reset asserted during a load-use stall clears everything immediately.
    @(negedge clk);
    id_valid = 1; id_src = 3'd5; id_dst = 3'd5; id_src_used = 1; id_dst_used = 1;
    id_imm_or_reg = 1; id_wb_en = 0; id_mem_read = 0; flush = 0; advance = 1;
    #2;
    check("pre_reset.stall", {7'd0, stall}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset.stall",     {7'd0, stall},     8'd0);
    check("mid_reset.ex_valid",  {7'd0, ex_valid},  8'd0);
    check("mid_reset.selectSrc", {6'd0, selectSrc}, 8'd0);
    check("mid_reset.selectDst", {6'd0, selectDst}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset",1, 3'd5, 3'd5, 1, 1, 1, 0, 0, 0, 1,  0, 1, 2'b00, 2'b00);
    step("idle_end",  0, 3'd0, 3'd0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 2'b00, 2'b00);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
